// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one synchronous-read memory port between instruction
//               fetch and data load/store, with bounded fetch starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_stall,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,

    input  logic            d_req,
    input  logic [3:0]      d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_stall,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,

    output logic            mem_en,
    output logic [3:0]      mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2
    } tag_t;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    tag_t            r_tag;
    tag_t            w_tag_next;
    logic [3:0]      r_starve_cnt;
    logic [XLEN-1:0] r_hold_if;
    logic [XLEN-1:0] r_hold_d;
    logic            w_force_if;
    logic            w_if_grant;
    logic            w_d_grant;

    // Grant depends only on requests and the starvation counter, never on mem_rdata.
    always_comb begin
        w_force_if = (r_starve_cnt == c_STARVE_LIMIT);
        w_if_grant = !reset && if_req && (!d_req || w_force_if);
        w_d_grant  = !reset && d_req && !w_if_grant;
        if_stall   = !reset && if_req && !w_if_grant;
        d_stall    = !reset && d_req && !w_d_grant;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_grant) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (w_d_grant) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        w_tag_next = TAG_NONE;
        if (w_if_grant) begin
            w_tag_next = TAG_IF;
        end else if (w_d_grant && (d_we == 4'b0000)) begin
            w_tag_next = TAG_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= TAG_NONE;
        end else begin
            r_tag <= w_tag_next;
        end
    end

    // A return whose owner was captured before reset is dropped while reset is high.
    assign if_rvalid = !reset && (r_tag == TAG_IF);
    assign d_rvalid  = !reset && (r_tag == TAG_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (if_req && !w_if_grant) begin
            if (r_starve_cnt != c_STARVE_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_if <= '0;
            r_hold_d  <= '0;
        end else begin
            if (if_rvalid) begin
                r_hold_if <= mem_rdata;
            end
            if (d_rvalid) begin
                r_hold_d <= mem_rdata;
            end
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : r_hold_if;
    assign d_rdata  = d_rvalid  ? mem_rdata : r_hold_d;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Scoreboard bench with a BRAM model and a reference arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        if_stall, if_rvalid, d_stall, d_rvalid, mem_en;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    logic [31:0] bram_q = '0;
    logic        rd_override = 1'b0;
    assign mem_rdata = rd_override ? 32'hDEADBEEF : bram_q;

    unified_mem_arbiter #(.XLEN(32), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory contents: environment BRAM and reference copy are kept apart.
    logic [31:0] bram    [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] k);
        return ({2'b00, k} * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [29:0] k;
        k = a[31:2];
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            logic [29:0] k;
            logic [31:0] w;
            k = mem_addr[31:2];
            w = bram.exists(k) ? bram[k] : init_word(k);
            w = merge(w, mem_wdata, mem_we);
            if (mem_we != 4'b0000) bram[k] = w;
            bram_q <= w;
        end
    end

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t q[$];

    // Reference arbiter state
    int   fetch_wait = 0;
    bit   last_s_if = 0, last_s_d = 0;
    logic        cur_ifr = 0, cur_dr = 0;
    logic [31:0] cur_ifa = 0, cur_da = 0, cur_dwd = 0;
    logic [3:0]  cur_dwe = 0;
    int   dstall_seen = 0;

    task automatic step(input logic rst_v, input logic ifr, input logic [31:0] ifa,
                        input logic dr, input logic [3:0] dwe, input logic [31:0] da,
                        input logic [31:0] dwd);
        bit g_if, g_d, s_if, s_d;
        @(posedge clk);
        #1;
        reset = rst_v; if_req = ifr; if_addr = ifa;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        cur_ifr = ifr; cur_ifa = ifa; cur_dr = dr; cur_dwe = dwe; cur_da = da; cur_dwd = dwd;
        if (rst_v) q.delete();
        #1;
        if (rst_v) begin
            g_if = 0; g_d = 0;
        end else begin
            g_if = ifr && (!dr || fetch_wait >= STARVE_LIMIT);
            g_d  = dr && !g_if;
        end
        s_if = !rst_v && ifr && !g_if;
        s_d  = !rst_v && dr && !g_d;
        if (d_stall) dstall_seen++;
        chk1("if_stall", if_stall, s_if);
        chk1("d_stall", d_stall, s_d);
        chk1("mem_en", mem_en, g_if || g_d);
        chk("mem_addr", mem_addr, g_if ? ifa : (g_d ? da : 32'h0));
        chk("mem_we", {28'h0, mem_we}, {28'h0, (g_d ? dwe : 4'b0000)});
        chk("mem_wdata", mem_wdata, g_d ? dwd : 32'h0);
        if (g_if) begin
            q.push_back('{is_d: 1'b0, data: ref_rd(ifa), due: cyc + 1});
        end else if (g_d && dwe == 4'b0000) begin
            q.push_back('{is_d: 1'b1, data: ref_rd(da), due: cyc + 1});
        end else if (g_d) begin
            ref_mem[da[31:2]] = merge(ref_rd(da), dwd, dwe);
        end
        if (rst_v || !(ifr && !g_if)) fetch_wait = 0;
        else fetch_wait++;
        last_s_if = s_if;
        last_s_d  = s_d;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rand_step();
        logic        ifr, dr;
        logic [31:0] ifa, da, dwd;
        logic [3:0]  dwe;
        ifr = cur_ifr; ifa = cur_ifa; dr = cur_dr; da = cur_da; dwe = cur_dwe; dwd = cur_dwd;
        if (!last_s_if) begin
            ifr = ($urandom_range(0, 99) < 60);
            ifa = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4;
        end
        if (!last_s_d) begin
            dr  = ($urandom_range(0, 99) < 60);
            da  = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4;
            dwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            dwd = $urandom;
        end
        step(0, ifr, ifa, dr, dwe, da, dwd);
    endtask

    // Monitor: pops the scoreboard when a response is due and checks held data.
    logic [31:0] hold_if_m = 0, hold_d_m = 0;
    always @(negedge clk) begin
        bit   exp_if, exp_d;
        rsp_t e;
        if (reset) begin
            chk1("rvalid_in_reset", if_rvalid | d_rvalid, 1'b0);
            hold_if_m = 0;
            hold_d_m  = 0;
        end else begin
            exp_if = 0; exp_d = 0;
            while (q.size() > 0 && q[0].due < cyc) begin
                n_tests++; n_fail++;
                $display("FAIL missed_rvalid: got none expected response due cycle %0d", q[0].due);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.is_d) exp_d = 1; else exp_if = 1;
            end
            chk1("if_rvalid", if_rvalid, exp_if);
            chk1("d_rvalid", d_rvalid, exp_d);
            if (exp_if) hold_if_m = e.data;
            if (exp_d)  hold_d_m  = e.data;
            chk("if_rdata", if_rdata, hold_if_m);
            chk("d_rdata", d_rdata, hold_d_m);
        end
    end

    initial begin
        ref_mem[30'h1000_0000] = 32'h0000_0013;
        bram[30'h1000_0000]    = 32'h0000_0013;

        // Reset with both requesters active and garbage on the read bus
        rd_override = 1'b1;
        repeat (3) step(1, 1, 32'h1000_0000, 1, 4'h0, 32'h1000_0004, 32'h0);
        idle();
        rd_override = 1'b0;

        // Fetch only
        step(0, 1, 32'h4000_0000, 0, 4'h0, 32'h0, 32'h0);
        idle(); idle();

        // Contention: data wins, fetch waits one cycle
        step(0, 1, 32'h4000_0000, 1, 4'h0, 32'h1000_0004, 32'h0);
        step(0, 1, 32'h4000_0000, 0, 4'h0, 32'h0, 32'h0);
        idle();

        // Continuous contention: fetch forced every STARVE_LIMIT+1 cycles
        dstall_seen = 0;
        repeat (12) step(0, 1, 32'h1000_0008, 1, 4'h0, 32'h1000_000C, 32'h0);
        chk("starve_forced_grants", 32'(dstall_seen), 32'(12 / (STARVE_LIMIT + 1)));
        step(0, 0, 32'h0, 1, 4'h0, 32'h1000_000C, 32'h0);
        idle();

        // Partial store then read-back of the same word
        step(0, 0, 32'h0, 1, 4'b0011, 32'h1000_0010, 32'h0000_BEEF);
        step(0, 0, 32'h0, 1, 4'b0000, 32'h1000_0010, 32'h0);
        idle();
        step(0, 0, 32'h0, 1, 4'b0011, 32'h1000_0014, 32'h1234_5678);
        idle(); idle();

        // Reset arriving right after a granted read
        step(0, 0, 32'h0, 1, 4'h0, 32'h1000_0018, 32'h0);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        step(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        idle(); idle();

        repeat (1500) rand_step();
        repeat (3) idle();
        @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
